// File: rtl/mbm_mac_accumulator.sv
// Frame multiply-accumulate stage behind a Mitchell log-domain approximate multiplier.
// Define MBM_MAC_SATURATE_EN to clamp the frame sum on overflow instead of wrapping.

module Mul_top #(
  parameter int N = 8,
  parameter int L = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en_i,
  input  logic [N-1:0]   b1_i,
  input  logic [N-1:0]   b2_i,
  output logic [2*N-1:0] p_o
);
  logic [L-1:0]   k1, k2;
  logic [N-2:0]   f1, f2;
  logic [L+N-1:0] logSum;
  logic [L:0]     charac;
  logic [3*N-1:0] mant;
  logic [2*N-1:0] prod;
  logic [2*N-1:0] p_q;

  // Leading-one position is the integer part of log2; the bits below it, left-aligned, are the fraction.
  always_comb begin
    k1 = '0;
    k2 = '0;
    for (int i = 0; i < N; i++) begin
      if (b1_i[i]) k1 = L'(i);
      if (b2_i[i]) k2 = L'(i);
    end
    f1     = (N-1)'(b1_i << (L'(N-1) - k1));
    f2     = (N-1)'(b2_i << (L'(N-1) - k2));
    logSum = {1'b0, k1, f1} + {1'b0, k2, f2};
    charac = logSum[L+N-1:N-1];
    mant   = {{(2*N){1'b0}}, 1'b1, logSum[N-2:0]};
    prod   = (2*N)'((mant << charac) >> (N-1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       p_q <= '0;
    else if (en_i) p_q <= prod;
  end

  assign p_o = p_q;
endmodule

module mbm_mac_accumulator #(
  parameter int N     = 8,
  parameter int L     = 3,
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_b1,
  input  logic [N-1:0]     in_b2,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);
  logic             en, accept, s1Zero;
  logic             s1Valid_q, s1Last_q, mValid_q, mLast_q, mZero_q, s2Valid_q, s2Last_q;
  logic [N-1:0]     s1B1_q, s1B2_q;
  logic [2*N-1:0]   mulProd, s2Prod_q;
  logic [ACC_W:0]   sumWide;
  logic             carry;
  logic [ACC_W-1:0] sumFinal;
  logic [CNT_W-1:0] cntNext;
  logic [ACC_W-1:0] acc_q, acc_d, outAcc_q, outAcc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, outCount_q, outCount_d;
  logic             ovf_q, ovf_d, outOvf_q, outOvf_d, outValid_q, outValid_d;

  assign en       = !(outValid_q && !out_ready);
  assign accept   = in_valid && en;
  assign in_ready = en;
  assign s1Zero   = (s1B1_q == '0) || (s1B2_q == '0);

  Mul_top #(.N(N), .L(L)) u_mul (
    .clk  (clk),
    .rst  (rst),
    .en_i (en),
    .b1_i (s1B1_q),
    .b2_i (s1B2_q),
    .p_o  (mulProd)
  );

  // Zero flag travels beside the multiplier register: leading-one detection of 0 gives a bogus product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid_q <= 1'b0;
      s1Last_q  <= 1'b0;
      s1B1_q    <= '0;
      s1B2_q    <= '0;
      mValid_q  <= 1'b0;
      mLast_q   <= 1'b0;
      mZero_q   <= 1'b0;
      s2Valid_q <= 1'b0;
      s2Last_q  <= 1'b0;
      s2Prod_q  <= '0;
    end else if (en) begin
      s1Valid_q <= accept;
      s1Last_q  <= in_last;
      s1B1_q    <= in_b1;
      s1B2_q    <= in_b2;
      mValid_q  <= s1Valid_q;
      mLast_q   <= s1Last_q;
      mZero_q   <= s1Zero;
      s2Valid_q <= mValid_q;
      s2Last_q  <= mLast_q;
      s2Prod_q  <= mZero_q ? '0 : mulProd;
    end
  end

  always_comb begin
    sumWide = {1'b0, acc_q} + {{(ACC_W+1-2*N){1'b0}}, s2Prod_q};
    carry   = sumWide[ACC_W];
`ifdef MBM_MAC_SATURATE_EN
    sumFinal = carry ? {ACC_W{1'b1}} : sumWide[ACC_W-1:0];
`else
    sumFinal = sumWide[ACC_W-1:0];
`endif
    cntNext = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // A last beat hands its total to the output and restarts the accumulator in the same cycle.
  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    outValid_d = outValid_q;
    outAcc_d   = outAcc_q;
    outCount_d = outCount_q;
    outOvf_d   = outOvf_q;
    if (en) begin
      if (outValid_q) outValid_d = 1'b0;
      if (s2Valid_q) begin
        if (s2Last_q) begin
          outAcc_d   = sumFinal;
          outCount_d = cntNext;
          outOvf_d   = ovf_q | carry;
          outValid_d = 1'b1;
          acc_d      = '0;
          cnt_d      = '0;
          ovf_d      = 1'b0;
        end else begin
          acc_d = sumFinal;
          cnt_d = cntNext;
          ovf_d = ovf_q | carry;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      outValid_q <= 1'b0;
      outAcc_q   <= '0;
      outCount_q <= '0;
      outOvf_q   <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      outValid_q <= outValid_d;
      outAcc_q   <= outAcc_d;
      outCount_q <= outCount_d;
      outOvf_q   <= outOvf_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_acc   = outAcc_q;
  assign out_count = outCount_q;
  assign out_ovf   = outOvf_q;
endmodule
